pipelined_wide_adder: RTL and testbench
=======================================

Name: pipelined_wide_adder

Overview:
- Parametrised, pipelined successor to the fixed 58+27-bit mixed-width adder.
- Adds an unsigned A_WIDTH operand to a B_WIDTH operand. B is zero- or sign-extended per transaction.
- Carry chain is split into CHUNK-bit slices, one pipeline stage per slice, so wide sums close timing in the FP datapath.
- Valid/ready handshake on both sides; carries an opaque tag for the mantissa/exponent pipeline.

Parameters:
- A_WIDTH, 58, width of operand A (unsigned).
- B_WIDTH, 27, width of operand B; must satisfy 1 <= B_WIDTH <= A_WIDTH.
- CHUNK, 16, bits resolved per pipeline stage; 1 <= CHUNK <= A_WIDTH+1.
- TAG_WIDTH, 4, sideband tag width, passed through unchanged.
- Derived: SW = A_WIDTH+1 (sum width); NSTAGES = ceil(SW/CHUNK), 4 at defaults.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- in_a  in  A_WIDTH  operand A.
- in_b  in  B_WIDTH  operand B.
- in_b_signed  in  1  1 = sign-extend B to SW bits; 0 = zero-extend B.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  SW  sum.
- out_tag  out  TAG_WIDTH  tag of the result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Arithmetic:
  - out_sum = (zext(A) + ext(B)) mod 2^SW, both operands extended to SW bits.
  - With in_b_signed=0 the result never wraps (max = 2^A_WIDTH - 1 + 2^B_WIDTH - 1 < 2^SW).
  - With in_b_signed=1 and negative B, the result is the SW-bit two's-complement pattern, wrapped.
- Pipeline structure:
  - Stage k (0..NSTAGES-1) adds operand bits [k*CHUNK +: CHUNK] plus the carry registered from stage k-1. Stage 0 carry-in is 0.
  - The last slice is SW - (NSTAGES-1)*CHUNK bits wide.
  - Unresolved upper operand slices are skewed forward through registers. Resolved lower sum slices are carried forward through registers.
- Latency and throughput:
  - Exactly NSTAGES cycles from the accepting edge (in_valid & in_ready) to out_valid, assuming no stall.
  - Throughput is one result per cycle.
- Flow control:
  - Global stall: advance = ~out_valid | out_ready; in_ready = advance.
  - On advance, every stage shifts one step. Per-stage valid bits track bubbles; a bubble may be overwritten.
  - When not advancing, all stage registers hold.
  - out_sum, out_tag and out_valid are stable while out_valid & ~out_ready.
- Handshake rules:
  - in_ready does not combinationally depend on in_valid.
  - Data is accepted only on in_valid & in_ready. in_valid without in_ready is ignored; upstream must hold its data.
- Reset:
  - All stage valid bits clear. out_valid=0, out_sum=0, out_tag=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight transactions without emitting them.
  - A transaction presented in a cycle where rst=1 is not accepted.
- Simultaneous events: out_ready & out_valid & in_valid in the same cycle retires the output and accepts the new input on the same edge. No bubble is inserted.
- NSTAGES=1: the block is a registered full-width adder with latency 1.

Optional Feature:
- Macro: PIPELINED_WIDE_ADDER_SUB_EN.
- When defined:
  - Extra input port in_sub (1 bit). When in_sub=1 the block computes (zext(A) - ext(B)) mod 2^SW.
  - Implemented as A + ~ext(B) with stage-0 carry-in = 1.
  - Extra output out_borrow (1 bit) = 1 when the subtract wraps below zero. Reset value 0.
  - in_sub and out_borrow travel with the transaction through the pipeline.
- When undefined: in_sub and out_borrow do not exist, and behaviour is add-only as above.

Test Plan:
- Carry across every slice: A=0x3FF_FFFF_FFFF_FFFF (2^58-1), B=1, in_b_signed=0, tag=5 -> after exactly 4 cycles out_sum=0x400_0000_0000_0000, out_tag=5.
- Sign extension: A=0, B=0x400_0000 (bit 26 set), in_b_signed=1 -> out_sum=0x7FF_FFFF_FC00_0000. Same operands with in_b_signed=0 -> out_sum=0x400_0000.
- Back-to-back throughput: 8 consecutive transactions (A=i, B=i, tag=i, i=0..7) with out_ready=1 -> 8 consecutive out_valid cycles, out_sum=2i in order, tags 0..7.
- Backpressure: drop out_ready for 3 cycles while the pipe is full -> in_ready=0 during the stall. Output held stable; no loss or duplication after release.
- Reset mid-operation: assert rst for 1 cycle with 3 transactions in flight -> next cycle out_valid=0, out_sum=0, in_ready=1. Those 3 transactions never appear.
- With PIPELINED_WIDE_ADDER_SUB_EN defined: A=5, B=7, in_sub=1 -> out_sum=0x7FF_FFFF_FFFF_FFFE, out_borrow=1. A=7, B=5, in_sub=1 -> out_sum=2, out_borrow=0.

Source files
------------

// File: rtl/pipelined_wide_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_wide_adder
// Description : Parametrised pipelined adder. It adds an unsigned A_WIDTH
//               operand to a B_WIDTH operand that is zero- or sign-extended
//               for each transaction. The result is A_WIDTH+1 bits wide. The
//               carry chain is cut into CHUNK-bit slices and each slice is
//               resolved in its own pipeline stage.
//
//               The optional subtract mode is enabled by the macro
//               PIPELINED_WIDE_ADDER_SUB_EN. It adds the in_sub input and the
//               out_borrow output.
//
// Ports       : clk, rst       - clock; synchronous active-high reset
//               in_valid       - input transaction present
//               in_ready       - input accepted this cycle
//               in_a           - operand A (unsigned, A_WIDTH)
//               in_b           - operand B (B_WIDTH)
//               in_b_signed    - 1: sign-extend B, 0: zero-extend B
//               in_sub         - (optional) 1: compute A - B
//               in_tag         - sideband tag, passed through unchanged
//               out_valid      - result present
//               out_ready      - downstream accepts the result
//               out_sum        - (A + ext(B)) mod 2^(A_WIDTH+1)
//               out_tag        - tag of the result
//               out_borrow     - (optional) subtract wrapped below zero
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_wide_adder #(
    parameter int A_WIDTH   = 58,
    parameter int B_WIDTH   = 27,
    parameter int CHUNK     = 16,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic                 in_b_signed,
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
    input  logic                 in_sub,
`endif
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_WIDTH:0]     out_sum,
    output logic [TAG_WIDTH-1:0] out_tag
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
    ,
    output logic                 out_borrow
`endif
);

    // Sum width and number of carry-resolution stages.
    localparam int c_SW      = A_WIDTH + 1;
    localparam int c_NSTAGES = (c_SW + CHUNK - 1) / CHUNK;

`ifdef PIPELINED_WIDE_ADDER_SUB_EN
    localparam bit c_SUB_EN  = 1'b1;
`else
    localparam bit c_SUB_EN  = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Operand preparation (stage 0 inputs)
    // ------------------------------------------------------------------------
    logic              w_advance;
    logic              w_b_neg;
    logic [c_SW-1:0]   w_a_ext;
    logic [c_SW-1:0]   w_b_ext;
    logic [c_SW-1:0]   w_b_op;
    logic              w_cin0;

    assign w_b_neg = in_b_signed & in_b[B_WIDTH-1];
    assign w_a_ext = {1'b0, in_a};
    // B_WIDTH <= A_WIDTH, so there is at least one extension bit.
    assign w_b_ext = {{(c_SW - B_WIDTH){w_b_neg}}, in_b};

`ifdef PIPELINED_WIDE_ADDER_SUB_EN
    // Subtraction is A + ~ext(B) + 1. The +1 enters as the stage-0 carry-in.
    assign w_b_op  = in_sub ? ~w_b_ext : w_b_ext;
    assign w_cin0  = in_sub;
`else
    assign w_b_op  = w_b_ext;
    assign w_cin0  = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Carry-resolution stages
    //
    // The register of stage k holds the following:
    //   r_sum : sum bits [c_HI-1:0], which are resolved up to and including
    //           this stage's slice
    //   r_cy  : carry out of this stage's slice
    //   r_a/b : the operand bits above this slice, still unresolved
    // The last stage keeps no operand bits and no carry. It holds only the
    // finished sum, plus the borrow flag when subtract mode is enabled.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < c_NSTAGES; k++) begin : g_stage
        localparam bit c_LAST = (k == c_NSTAGES - 1);
        localparam int c_LO   = k * CHUNK;
        localparam int c_W    = c_LAST ? (c_SW - c_LO) : CHUNK;
        localparam int c_HI   = c_LO + c_W;
        // The slice adder needs its carry-out bit except in the last stage.
        // In the last stage the carry is only needed to derive the borrow.
        localparam int c_SLW  = (c_LAST && !c_SUB_EN) ? c_W : c_W + 1;

        logic                 w_vld_in;
        logic [TAG_WIDTH-1:0] w_tag_in;
        logic [c_SW-1:c_LO]   w_a_in;
        logic [c_SW-1:c_LO]   w_b_in;
        logic                 w_cy_in;
        logic [c_SLW-1:0]     w_slice;
        logic [c_HI-1:0]      w_sum_nx;
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
        logic                 w_sub_in;
        logic                 w_bs_in;
`endif

        logic                 r_vld;
        logic [c_HI-1:0]      r_sum;
        logic [TAG_WIDTH-1:0] r_tag;

        // Stage inputs come from the ports for stage 0. For every later
        // stage they come from the previous stage's registers.
        if (k == 0) begin : g_src_port
            assign w_vld_in = in_valid;
            assign w_tag_in = in_tag;
            assign w_a_in   = w_a_ext;
            assign w_b_in   = w_b_op;
            assign w_cy_in  = w_cin0;
            assign w_sum_nx = w_slice[c_W-1:0];
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
            assign w_sub_in = in_sub;
            assign w_bs_in  = w_b_neg;
`endif
        end else begin : g_src_prev
            assign w_vld_in = g_stage[k-1].r_vld;
            assign w_tag_in = g_stage[k-1].r_tag;
            assign w_a_in   = g_stage[k-1].g_fwd.r_a;
            assign w_b_in   = g_stage[k-1].g_fwd.r_b;
            assign w_cy_in  = g_stage[k-1].g_fwd.r_cy;
            assign w_sum_nx = {w_slice[c_W-1:0], g_stage[k-1].r_sum};
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
            assign w_sub_in = g_stage[k-1].g_fwd.r_sub;
            assign w_bs_in  = g_stage[k-1].g_fwd.r_bs;
`endif
        end

        assign w_slice = c_SLW'(w_a_in[c_HI-1:c_LO])
                       + c_SLW'(w_b_in[c_HI-1:c_LO])
                       + c_SLW'(w_cy_in);

        // Every stage shifts together on w_advance. A bubble (r_vld = 0)
        // shifts like data and is therefore overwritten by whatever follows.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_sum <= '0;
                r_tag <= '0;
            end else if (w_advance) begin
                r_vld <= w_vld_in;
                r_sum <= w_sum_nx;
                r_tag <= w_tag_in;
            end
        end

        if (!c_LAST) begin : g_fwd
            logic [c_SW-1:c_HI] r_a;
            logic [c_SW-1:c_HI] r_b;
            logic               r_cy;
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
            logic               r_sub;
            logic               r_bs;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a  <= '0;
                    r_b  <= '0;
                    r_cy <= 1'b0;
                end else if (w_advance) begin
                    r_a  <= w_a_in[c_SW-1:c_HI];
                    r_b  <= w_b_in[c_SW-1:c_HI];
                    r_cy <= w_slice[c_W];
                end
            end

`ifdef PIPELINED_WIDE_ADDER_SUB_EN
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sub <= 1'b0;
                    r_bs  <= 1'b0;
                end else if (w_advance) begin
                    r_sub <= w_sub_in;
                    r_bs  <= w_bs_in;
                end
            end
`endif
        end

`ifdef PIPELINED_WIDE_ADDER_SUB_EN
        if (c_LAST) begin : g_borrow
            // Treat the difference as an (SW+1)-bit signed number. Its top
            // bit is ~bsign + carry_out (mod 2), with bsign = sign of ext(B).
            // A set top bit means A - B < 0.
            logic r_borrow;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_borrow <= 1'b0;
                end else if (w_advance) begin
                    r_borrow <= w_sub_in & ~(w_slice[c_W] ^ w_bs_in);
                end
            end
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Flow control and outputs
    // ------------------------------------------------------------------------
    // A single global stall. in_ready depends only on state and out_ready,
    // never on in_valid.
    assign w_advance = ~g_stage[c_NSTAGES-1].r_vld | out_ready;
    assign in_ready  = w_advance;

    assign out_valid = g_stage[c_NSTAGES-1].r_vld;
    assign out_sum   = g_stage[c_NSTAGES-1].r_sum;
    assign out_tag   = g_stage[c_NSTAGES-1].r_tag;
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
    assign out_borrow = g_stage[c_NSTAGES-1].g_borrow.r_borrow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_wide_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_wide_adder
// Description : Scoreboard bench for pipelined_wide_adder at default
//               parameters. Expected results are queued when each input is
//               accepted. They are compared while the output is valid and
//               popped when the output is retired.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_wide_adder;

    localparam int A_W = 58;
    localparam int B_W = 27;
    localparam int CH  = 16;
    localparam int T_W = 4;
    localparam int SW  = A_W + 1;
    localparam int NST = (SW + CH - 1) / CH;
    localparam logic [63:0] c_MASK = (64'd1 << SW) - 64'd1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] in_a;
    logic [B_W-1:0] in_b;
    logic           in_b_signed;
    logic [T_W-1:0] in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_sum;
    logic [T_W-1:0] out_tag;
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
    logic           in_sub;
    logic           out_borrow;
`endif

    pipelined_wide_adder #(
        .A_WIDTH   (A_W),
        .B_WIDTH   (B_W),
        .CHUNK     (CH),
        .TAG_WIDTH (T_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_b_signed (in_b_signed),
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
        .in_sub      (in_sub),
`endif
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_tag     (out_tag)
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
        ,
        .out_borrow  (out_borrow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]    sum;
        logic [T_W-1:0] tag;
        logic           borrow;
        int             cyc;
        bit             lat;
    } exp_t;

    exp_t q[$];
    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    bit   head_seen = 1'b0;
    bit   rand_rdy  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [63:0] act,
                            input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on a 64-bit longint.
    function automatic logic [63:0] model(input logic [A_W-1:0] a,
                                          input logic [B_W-1:0] b,
                                          input bit bs, input bit sub,
                                          output bit brw);
        longint av;
        longint bv;
        longint r;
        av = longint'(a);
        bv = longint'(b);
        if (bs && b[B_W-1]) bv = bv - (longint'(1) << B_W);
        r   = sub ? (av - bv) : (av + bv);
        brw = sub && (r < 0);
        return 64'(r) & c_MASK;
    endfunction

    // Present one transaction and hold it until it is accepted. The expected
    // sum comes from the model unless use_xs supplies a literal value.
    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input bit bs, input bit sub, input logic [T_W-1:0] tg,
                        input bit lat, input bit use_xs, input logic [63:0] xs);
        bit          acc;
        bit          xb;
        int          n;
        logic [63:0] xm;
        xm = model(a, b, bs, sub, xb);
        if (use_xs) xm = xs;
        in_valid    = 1'b1;
        in_a        = a;
        in_b        = b;
        in_b_signed = bs;
        in_tag      = tg;
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
        in_sub      = sub;
`endif
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                acc = 1'b1;
                q.push_back('{sum: xm, tag: tg, borrow: xb, cyc: cyc, lat: lat});
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rand(input bit sub);
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        send(r64[A_W-1:0], B_W'($urandom()), bit'($urandom_range(0, 1)), sub,
             T_W'($urandom()), 1'b0, 1'b0, 64'd0);
    endtask

    // Output monitor. While the output is valid, the head of the queue must
    // match it, including during stalls. The head is popped on retirement.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            head_seen = 1'b0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                check_eq("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                check_eq("out_sum", 64'(out_sum), q[0].sum);
                check_eq("out_tag", 64'(out_tag), 64'(q[0].tag));
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
                check_eq("out_borrow", 64'(out_borrow), 64'(q[0].borrow));
`endif
                if (!head_seen && q[0].lat)
                    check_eq("latency", 64'(cyc - q[0].cyc), 64'(NST));
                head_seen = 1'b1;
                if (out_ready) begin
                    void'(q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    // Random backpressure, active only while rand_rdy is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_b_signed = 1'b0;
        in_tag      = '0;
        out_ready   = 1'b1;
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
        in_sub      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_sum",   64'(out_sum),   64'd0);
        check_eq("rst_out_tag",   64'(out_tag),   64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
`ifdef PIPELINED_WIDE_ADDER_SUB_EN
        check_eq("rst_out_borrow", 64'(out_borrow), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Carry ripples across every slice; sign and zero extension of B
        send(58'h3FF_FFFF_FFFF_FFFF, 27'd1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1,
             64'h400_0000_0000_0000);
        send(58'd0, 27'h400_0000, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1,
             64'h7FF_FFFF_FC00_0000);
        send(58'd0, 27'h400_0000, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1,
             64'h400_0000);
        idle(NST + 2);

        // Back-to-back throughput
        for (int i = 0; i < 8; i++)
            send(A_W'(i), B_W'(i), 1'b0, 1'b0, T_W'(i), 1'b1, 1'b1, 64'(2 * i));
        idle(NST + 2);

        // Backpressure: fill the pipe with out_ready low, then hold it for
        // 3 cycles while a fifth transaction waits at the input
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_rand(1'b0);
        fork
            send_rand(1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_eq("stall_in_ready",  64'(in_ready),  64'd0);
                    check_eq("stall_out_valid", 64'(out_valid), 64'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        send_rand(1'b0);
        send_rand(1'b0);
        idle(NST + 2);

        // Reset with 3 transactions in flight and one presented during rst
        for (int i = 0; i < 3; i++) send_rand(1'b0);
        in_valid = 1'b1;
        in_a     = 58'd123;
        in_b     = 27'd1;
        in_tag   = 4'd9;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_out_sum",   64'(out_sum),   64'd0);
        check_eq("midrst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        idle(NST + 3);

        // Random traffic under random backpressure
        rand_rdy = 1'b1;
        repeat (40) send_rand(1'b0);
        rand_rdy  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(NST + 4);

`ifdef PIPELINED_WIDE_ADDER_SUB_EN
        send(58'd5, 27'd7, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 64'h7FF_FFFF_FFFF_FFFE);
        send(58'd7, 27'd5, 1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 64'd2);
        repeat (12) send_rand(bit'($urandom_range(0, 1)));
        idle(NST + 4);
`endif

        check_eq("drain_queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
